// File: rtl/qtree_match_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qtree_match_writer_pkg
// Purpose  : Shared match-RAM word layout, clear word and writer FSM states
//            for the qtree match table.
// Revision : 1.0 - initial release
// ============================================================================
package qtree_match_writer_pkg;

  // Key width of the default match-table build.
  localparam int MATCH_KEY_WIDTH = 16;

  // One match-cell RAM word: inclusive range [l, r], l in the upper half.
  typedef struct packed {
    logic [MATCH_KEY_WIDTH-1:0] l;
    logic [MATCH_KEY_WIDTH-1:0] r;
  } match_ram_data_t;

  // Invalidated cell: l > r for every key, so the cell can never match.
  localparam match_ram_data_t MATCH_CLEAR_WORD = '{l: '1, r: '0};

  // Writer sequencing states.
  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_CLEAR = 1'b1
  } wr_state_e;

  // Build a RAM word from a rule's bounds.
  function automatic match_ram_data_t pack_rule(input logic [MATCH_KEY_WIDTH-1:0] l,
                                                input logic [MATCH_KEY_WIDTH-1:0] r);
    match_ram_data_t w;
    w.l = l;
    w.r = r;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qtree_match_writer.sv
`default_nettype none
// ============================================================================
// Module   : qtree_match_writer
// Purpose  : Write port sequencer for the qtree match-cell RAMs. Forwards
//            configuration rules as single-cycle RAM writes and runs a full
//            table invalidation (clear) on request or after reset.
// Revision : 1.0 - initial release
// ============================================================================
module qtree_match_writer
  import qtree_match_writer_pkg::*;
#(
  parameter int KEY_WIDTH            = 16,
  parameter int RAM_ADDR_WIDTH       = 8,
  parameter int MATCH_CELL_CNT       = 4,
  parameter int MATCH_CELL_CNT_WIDTH = (MATCH_CELL_CNT > 1) ? $clog2(MATCH_CELL_CNT) : 1,
  parameter int RAM_DATA_WIDTH       = 2 * KEY_WIDTH,
  parameter bit CLEAR_ON_RESET       = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [RAM_ADDR_WIDTH-1:0]       cfg_addr_i,
  input  logic [MATCH_CELL_CNT_WIDTH-1:0] cfg_cell_i,
  input  logic [KEY_WIDTH-1:0]            cfg_l_i,
  input  logic [KEY_WIDTH-1:0]            cfg_r_i,
  input  logic                            cfg_valid_i,
  output logic                            cfg_ready_o,
  input  logic                            clear_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [RAM_DATA_WIDTH-1:0]       ram_data_o,
  output logic [RAM_ADDR_WIDTH-1:0]       ram_addr_o,
  output logic [MATCH_CELL_CNT_WIDTH-1:0] ram_cell_o,
  output logic                            ram_write_o,
  output logic [15:0]                     wr_cnt_o
);

  // Last cell index of the inner clear loop.
  localparam logic [MATCH_CELL_CNT_WIDTH-1:0] LAST_CELL =
    MATCH_CELL_CNT_WIDTH'(MATCH_CELL_CNT - 1);

  // Clear word {l = all ones, r = 0}, same layout as MATCH_CLEAR_WORD.
  localparam logic [RAM_DATA_WIDTH-1:0] CLEAR_WORD =
    RAM_DATA_WIDTH'({{KEY_WIDTH{1'b1}}, {KEY_WIDTH{1'b0}}});

  wr_state_e state;
  logic      start_clear;   // clear requested by reset release, not yet started
  logic      accept_rule;
  logic      clear_last;

  // Rules are only taken when idle and no clear is competing for the port.
  assign cfg_ready_o = !rst_i && (state == WR_IDLE) && !clear_i && !start_clear;
  assign accept_rule = cfg_valid_i && cfg_ready_o;

  // In CLEAR the ram_addr/ram_cell outputs are the sweep counter itself.
  assign clear_last  = (ram_addr_o == {RAM_ADDR_WIDTH{1'b1}}) && (ram_cell_o == LAST_CELL);

  // FSM, write port registers and rule counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= WR_IDLE;
      start_clear <= CLEAR_ON_RESET;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ram_write_o <= 1'b0;
      ram_data_o  <= '0;
      ram_addr_o  <= '0;
      ram_cell_o  <= '0;
      wr_cnt_o    <= '0;
    end else begin
      done_o      <= 1'b0;
      ram_write_o <= 1'b0;
      case (state)
        WR_IDLE: begin
          if (clear_i || start_clear) begin
            // First clear write goes out in the cycle after acceptance.
            state       <= WR_CLEAR;
            start_clear <= 1'b0;
            busy_o      <= 1'b1;
            ram_write_o <= 1'b1;
            ram_data_o  <= CLEAR_WORD;
            ram_addr_o  <= '0;
            ram_cell_o  <= '0;
          end else if (accept_rule) begin
            // Bounds are written as given; an l > r rule simply never matches.
            ram_write_o <= 1'b1;
            ram_data_o  <= RAM_DATA_WIDTH'({cfg_l_i, cfg_r_i});
            ram_addr_o  <= cfg_addr_i;
            ram_cell_o  <= cfg_cell_i;
            if (wr_cnt_o != 16'hFFFF) begin
              wr_cnt_o <= wr_cnt_o + 16'd1;
            end
          end
        end
        WR_CLEAR: begin
          // clear_i is ignored here: no restart and no queued request.
          if (clear_last) begin
            state  <= WR_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            ram_write_o <= 1'b1;
            if (ram_cell_o == LAST_CELL) begin
              ram_cell_o <= '0;
              ram_addr_o <= ram_addr_o + 1'b1;
            end else begin
              ram_cell_o <= ram_cell_o + 1'b1;
            end
          end
        end
        default: begin
          state <= WR_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qtree_match_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtree_match_writer
// Purpose  : Directed self-checking bench for qtree_match_writer with a small
//            behavioural match-table model fed by the RAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qtree_match_writer;
  import qtree_match_writer_pkg::*;

  localparam int KW = 16;
  localparam int AW = 3;
  localparam int CC = 4;
  localparam int CW = 2;
  localparam int DW = 32;
  localparam logic [DW-1:0] CLR = 32'hFFFF0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_cell = '0;
  logic [KW-1:0] cfg_l = '0;
  logic [KW-1:0] cfg_r = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          clear = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] ram_cell;
  logic          ram_write;
  logic [15:0]   wr_cnt;

  int passed = 0;
  int total  = 0;

  // Behavioural match table written through the DUT's RAM port.
  logic [DW-1:0] mem [0:(1<<AW)-1][0:CC-1];

  qtree_match_writer #(
    .KEY_WIDTH(KW), .RAM_ADDR_WIDTH(AW), .MATCH_CELL_CNT(CC),
    .MATCH_CELL_CNT_WIDTH(CW), .RAM_DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_addr_i(cfg_addr), .cfg_cell_i(cfg_cell), .cfg_l_i(cfg_l), .cfg_r_i(cfg_r),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .clear_i(clear), .busy_o(busy), .done_o(done),
    .ram_data_o(ram_data), .ram_addr_o(ram_addr), .ram_cell_o(ram_cell),
    .ram_write_o(ram_write), .wr_cnt_o(wr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr][ram_cell] <= ram_data;
  end

  // Range lookup: bit c set when l <= key <= r for cell c at address a.
  function automatic logic [CC-1:0] lookup(input int a, input logic [KW-1:0] key);
    logic [CC-1:0] hit;
    hit = '0;
    for (int c = 0; c < CC; c++) begin
      if (mem[a][c][31:16] <= key && key <= mem[a][c][15:0]) hit[c] = 1'b1;
    end
    return hit;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ram_write, ram_addr, ram_cell, ram_data, busy, done, wr_cnt, cfg_ready} !== '0) begin
      $display("FAIL reset_state: write=%b addr=%0d cell=%0d data=%h busy=%b done=%b cnt=%0d ready=%b, required all zero",
               ram_write, ram_addr, ram_cell, ram_data, busy, done, wr_cnt, cfg_ready);
    end else passed++;
  endtask

  task automatic test_clear_on_reset();
    logic [AW-1:0] ea;
    logic [CW-1:0] ec;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      ea = AW'(k / 4);
      ec = CW'(k % 4);
      total++;
      if ({ram_write, ram_addr, ram_cell, ram_data, busy, done} !== {1'b1, ea, ec, CLR, 1'b1, 1'b0}) begin
        $display("FAIL reset_clear_write%0d: write=%b addr=%0d cell=%0d data=%h busy=%b done=%b, required 1 %0d %0d %h 1 0",
                 k, ram_write, ram_addr, ram_cell, ram_data, busy, done, ea, ec, CLR);
      end else passed++;
    end
    @(posedge clk); #1;
    total++;
    if ({ram_write, busy, done, cfg_ready} !== 4'b0011) begin
      $display("FAIL reset_clear_done: write=%b busy=%b done=%b ready=%b, required 0 0 1 1",
               ram_write, busy, done, cfg_ready);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      $display("FAIL done_single_pulse: done=%b, required 0", done);
    end else passed++;
  endtask

  task automatic test_lookup_cleared();
    total++;
    if (lookup(5, 16'h0018) !== 4'b0000) begin
      $display("FAIL lookup_cleared: hit=%b, required 0000", lookup(5, 16'h0018));
    end else passed++;
  endtask

  task automatic test_single_rule();
    cfg_addr = 3'd5; cfg_cell = 2'd2; cfg_l = 16'h0010; cfg_r = 16'h0020; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    total++;
    if ({ram_write, ram_addr, ram_cell, ram_data, wr_cnt} !== {1'b1, 3'd5, 2'd2, 32'h00100020, 16'd1}) begin
      $display("FAIL single_rule: write=%b addr=%0d cell=%0d data=%h cnt=%0d, required 1 5 2 00100020 1",
               ram_write, ram_addr, ram_cell, ram_data, wr_cnt);
    end else passed++;
    @(posedge clk); #1;
    total++;
    if ({ram_write, ram_addr, ram_cell, ram_data} !== {1'b0, 3'd5, 2'd2, 32'h00100020}) begin
      $display("FAIL rule_hold: write=%b addr=%0d cell=%0d data=%h, required 0 5 2 00100020",
               ram_write, ram_addr, ram_cell, ram_data);
    end else passed++;
    total++;
    if (lookup(5, 16'h0018) !== 4'b0100) begin
      $display("FAIL lookup_rule: hit=%b, required 0100", lookup(5, 16'h0018));
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0]  ta [3];
    logic [CW-1:0]  tc [3];
    logic [DW-1:0]  td [3];
    ta = '{3'd1, 3'd2, 3'd7};
    tc = '{2'd0, 2'd1, 2'd3};
    td = '{32'h00010002, 32'h00500040, 32'hABCDABCD};  // middle rule has l > r
    for (int i = 0; i < 3; i++) begin
      cfg_addr = ta[i]; cfg_cell = tc[i]; cfg_l = td[i][31:16]; cfg_r = td[i][15:0];
      cfg_valid = 1'b1;
      total++;
      if (cfg_ready !== 1'b1) begin
        $display("FAIL b2b_ready%0d: ready=%b, required 1", i, cfg_ready);
      end else passed++;
      @(posedge clk); #1;
      total++;
      if ({ram_write, ram_addr, ram_cell, ram_data} !== {1'b1, ta[i], tc[i], td[i]}) begin
        $display("FAIL b2b_write%0d: write=%b addr=%0d cell=%0d data=%h, required 1 %0d %0d %h",
                 i, ram_write, ram_addr, ram_cell, ram_data, ta[i], tc[i], td[i]);
      end else passed++;
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ram_write, wr_cnt} !== {1'b0, 16'd4}) begin
      $display("FAIL b2b_count: write=%b cnt=%0d, required 0 4", ram_write, wr_cnt);
    end else passed++;
    total++;
    if (lookup(2, 16'h0045) !== 4'b0000) begin
      $display("FAIL lookup_inverted: hit=%b, required 0000", lookup(2, 16'h0045));
    end else passed++;
  endtask

  task automatic test_clear_priority();
    logic [AW-1:0] ea;
    logic [CW-1:0] ec;
    clear = 1'b1;
    cfg_addr = 3'd6; cfg_cell = 2'd1; cfg_l = 16'h1111; cfg_r = 16'h2222; cfg_valid = 1'b1;
    #1;
    total++;
    if (cfg_ready !== 1'b0) begin
      $display("FAIL prio_ready: ready=%b, required 0", cfg_ready);
    end else passed++;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      // Re-request clear mid-sweep; it must be ignored.
      clear = (k >= 5 && k < 8);
      ea = AW'(k / 4);
      ec = CW'(k % 4);
      total++;
      if ({ram_write, ram_addr, ram_cell, ram_data, busy, cfg_ready, wr_cnt} !==
          {1'b1, ea, ec, CLR, 1'b1, 1'b0, 16'd4}) begin
        $display("FAIL prio_clear_write%0d: write=%b addr=%0d cell=%0d data=%h busy=%b ready=%b cnt=%0d, required 1 %0d %0d %h 1 0 4",
                 k, ram_write, ram_addr, ram_cell, ram_data, busy, cfg_ready, wr_cnt, ea, ec, CLR);
      end else passed++;
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ram_write, busy, done, wr_cnt} !== {1'b0, 1'b0, 1'b1, 16'd4}) begin
      $display("FAIL prio_done: write=%b busy=%b done=%b cnt=%0d, required 0 0 1 4",
               ram_write, busy, done, wr_cnt);
    end else passed++;
    total++;
    if (lookup(5, 16'h0018) !== 4'b0000) begin
      $display("FAIL lookup_recleared: hit=%b, required 0000", lookup(5, 16'h0018));
    end else passed++;
  endtask

  task automatic test_reset_abort();
    logic [AW-1:0] ea;
    logic [CW-1:0] ec;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if ({ram_write, ram_addr, ram_cell} !== {1'b1, 3'd2, 2'd2}) begin
      $display("FAIL abort_write10: write=%b addr=%0d cell=%0d, required 1 2 2", ram_write, ram_addr, ram_cell);
    end else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ram_write, busy, done, wr_cnt, cfg_ready, ram_addr} !== '0) begin
      $display("FAIL abort_reset: write=%b busy=%b done=%b cnt=%0d ready=%b addr=%0d, required all zero",
               ram_write, busy, done, wr_cnt, cfg_ready, ram_addr);
    end else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      ea = AW'(k / 4);
      ec = CW'(k % 4);
      total++;
      if ({ram_write, ram_addr, ram_cell, ram_data, busy} !== {1'b1, ea, ec, CLR, 1'b1}) begin
        $display("FAIL abort_fresh_write%0d: write=%b addr=%0d cell=%0d data=%h busy=%b, required 1 %0d %0d %h 1",
                 k, ram_write, ram_addr, ram_cell, ram_data, busy, ea, ec, CLR);
      end else passed++;
    end
    @(posedge clk); #1;
    total++;
    if ({ram_write, busy, done, cfg_ready} !== 4'b0011) begin
      $display("FAIL abort_fresh_done: write=%b busy=%b done=%b ready=%b, required 0 0 1 1",
               ram_write, busy, done, cfg_ready);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_clear_on_reset();
    test_lookup_cleared();
    test_single_rule();
    test_back_to_back();
    test_clear_priority();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qtree_match_writer.md
QTREE_MATCH_WRITER -- requirements
Module: qtree_match_writer

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 16, width of range bounds l and r.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 8, address width of each match-cell RAM.
REQ-003 SHALL have parameter MATCH_CELL_CNT, default 4, number of match cells (RAMs) per address.
REQ-004 SHALL have parameter MATCH_CELL_CNT_WIDTH, default max(1,$clog2(MATCH_CELL_CNT)), cell index width.
REQ-005 SHALL have parameter RAM_DATA_WIDTH, default 2*KEY_WIDTH, packed match RAM word width.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, which starts a full clear after reset.
REQ-007 SHALL have clk_i  input  1  the single clock; all logic on rising edge.
REQ-008 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-009 SHALL have cfg_addr_i  input  RAM_ADDR_WIDTH  target RAM address of rule.
REQ-010 SHALL have cfg_cell_i  input  MATCH_CELL_CNT_WIDTH  target match cell of rule.
REQ-011 SHALL have cfg_l_i / cfg_r_i  input  KEY_WIDTH each  rule lower/upper bound, inclusive.
REQ-012 SHALL have cfg_valid_i  input  1 and cfg_ready_o  output  1  rule handshake.
REQ-013 SHALL have clear_i  input  1  request to invalidate every cell at every address.
REQ-014 SHALL have busy_o  output  1  high while a clear sequence is running.
REQ-015 SHALL have done_o  output  1  one-cycle pulse when a clear sequence completes.
REQ-016 SHALL have ram_data_o  output  RAM_DATA_WIDTH, ram_addr_o  output  RAM_ADDR_WIDTH, ram_cell_o  output  MATCH_CELL_CNT_WIDTH, ram_write_o  output  1  write port driving the lookup block's ram_*_i inputs.
REQ-017 SHALL have wr_cnt_o  output  16  count of rule writes issued, saturating at 16'hFFFF.

Function
REQ-018 SHALL pack ram_data_o as match_ram_data_t {l in upper KEY_WIDTH bits, r in lower}.
REQ-019 SHALL implement states IDLE and CLEAR; IDLE->CLEAR on clear_i, CLEAR->IDLE after last clear write.
REQ-020 SHALL drive cfg_ready_o = (state==IDLE) && !clear_i, combinationally.
REQ-021 SHALL, for a rule accepted at edge N (valid&&ready), assert ram_write_o for exactly the cycle after edge N with registered addr/cell/data; throughput one rule per cycle.
REQ-022 SHALL write l>r rules unchanged (such a cell never matches); no range check.
REQ-023 SHALL, in CLEAR, issue one write per cycle with data {l=all ones, r=0}, cell as inner loop 0..MATCH_CELL_CNT-1, address as outer loop 0..2^RAM_ADDR_WIDTH-1, total MATCH_CELL_CNT*2^RAM_ADDR_WIDTH consecutive writes.
REQ-024 SHALL give clear_i priority over cfg_valid_i in the same cycle; the rule is not accepted.
REQ-025 SHALL ignore clear_i while in CLEAR (no restart, no queueing).
REQ-026 SHALL assert busy_o from the cycle after clear acceptance through the cycle of the last clear write.
REQ-027 SHALL pulse done_o in the cycle after the last clear write, coincident with return to IDLE.
REQ-028 SHALL hold ram_write_o low in any cycle with no rule write or clear write; other ram_* outputs hold last value.
REQ-029 SHALL increment wr_cnt_o only on rule writes, never on clear writes.

Reset
REQ-030 SHALL, while rst_i high, force state IDLE, ram_write_o=0, ram_data_o/ram_addr_o/ram_cell_o=0, busy_o=0, done_o=0, wr_cnt_o=0, cfg_ready_o=0.
REQ-031 SHALL, with CLEAR_ON_RESET=1, enter CLEAR on the first cycle after rst_i deasserts; with 0, enter IDLE.
REQ-032 SHALL abort any clear or pending write immediately when rst_i asserts mid-operation; no partial write after reset.

Structure
REQ-033 SHALL take match_ram_data_t and the clear word constant from the shared RAM definitions include used by qtree_match.
REQ-034 SHALL be a single module with no sub-modules; counters and FSM inline.

Verification
REQ-035 SHALL cover (KEY_WIDTH=16, RAM_ADDR_WIDTH=3, MATCH_CELL_CNT=4): reset release, CLEAR_ON_RESET=1 -> 32 writes addr/cell 0/0,0/1..7/3, data 32'hFFFF0000, done_o at cycle 33, cfg_ready_o then high.
REQ-036 SHALL cover rule addr=5 cell=2 l=16'h0010 r=16'h0020 -> one cycle later ram_write_o=1, addr 5, cell 2, data 32'h00100020, wr_cnt_o=1.
REQ-037 SHALL cover three back-to-back rules -> three consecutive write cycles, wr_cnt_o=3.
REQ-038 SHALL cover clear_i and cfg_valid_i together in IDLE -> rule not accepted, clear runs, wr_cnt_o unchanged.
REQ-039 SHALL cover rst_i asserted at clear write 10 -> ram_write_o=0 next cycle, then fresh 32-write clear after release.
REQ-040 SHALL cover ram_* outputs driving qtree_match -> cleared table gives no match; after rule write, lookup of 16'h0018 at addr 5 matches cell 2.
